// File: rtl/dvs_aer_tx.sv
// Word-serial AER transmitter emulating the DVS camera side of the bus.
// Buffered events are sent as an optional Y word plus an X word over a four-phase req/ack handshake.
module dvs_aer_tx #(
  parameter int X_BITS             = 9,
  parameter int Y_BITS             = 9,
  parameter int FIFO_DEPTH         = 4,
  parameter int SETUP_CYCLES       = 1,
  parameter int MIN_EVENT_CYCLES   = 9,
  parameter int ROW_TIMEOUT_CYCLES = 100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ev_valid,
  output logic              ev_ready,
  input  logic [X_BITS-1:0] ev_x,
  input  logic [Y_BITS-1:0] ev_y,
  input  logic              ev_pol,
  output logic [9:0]        aer,
  output logic              xsel,
  output logic              req,
  input  logic              ack,
  output logic              busy,
  output logic [15:0]       event_count
);
  localparam int EW  = X_BITS + Y_BITS + 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int GW  = (MIN_EVENT_CYCLES < 1) ? 1 : $clog2(MIN_EVENT_CYCLES + 1);
  localparam int SW  = (SETUP_CYCLES < 1) ? 1 : $clog2(SETUP_CYCLES + 1);
  localparam int TW  = (ROW_TIMEOUT_CYCLES < 1) ? 1 : $clog2(ROW_TIMEOUT_CYCLES + 1);
  localparam logic [GW-1:0]  GAP_LOAD   = GW'(MIN_EVENT_CYCLES);
  localparam logic [SW-1:0]  SETUP_LOAD = SW'(SETUP_CYCLES);
  localparam logic [TW-1:0]  TIMEOUT    = TW'(ROW_TIMEOUT_CYCLES);
  localparam logic [AW1-1:0] DEPTH      = AW1'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    REQ_HI = 3'd2,
    REQ_LO = 3'd3,
    GAP    = 3'd4
  } state_t;

  function automatic logic [9:0] y_word(input logic [Y_BITS-1:0] y);
    return {1'b0, 9'(y)};
  endfunction

  function automatic logic [9:0] x_word(input logic [X_BITS-1:0] x, input logic pol);
    return {9'(x), pol};
  endfunction

  logic [EW-1:0]     mem_r [FIFO_DEPTH];
  logic [AW1-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW1-1:0]    count_s;
  logic              full_s, empty_s, push_s, pop_s, needs_y_s;
  logic [EW-1:0]     head_s;
  logic [Y_BITS-1:0] head_y_s;
  logic [X_BITS-1:0] head_x_s;
  logic              head_pol_s;

  logic              ack_meta_r, ack_s;
  state_t            state_r;
  logic [SW-1:0]     setup_cnt_r;
  logic [GW-1:0]     gap_cnt_r;
  logic [TW-1:0]     idle_cnt_r;
  logic [Y_BITS-1:0] last_y_r, cur_y_r;
  logic              last_y_valid_r;
  logic [X_BITS-1:0] cur_x_r;
  logic              cur_pol_r;
  logic              first_rise_r;

  assign count_s    = wr_ptr_r - rd_ptr_r;
  assign full_s     = (count_s == DEPTH);
  assign empty_s    = (wr_ptr_r == rd_ptr_r);
  assign push_s     = ev_valid && !full_s;
  assign pop_s      = (state_r == IDLE) && !empty_s && (gap_cnt_r == GW'(0));
  assign head_s     = mem_r[rd_ptr_r[AW-1:0]];
  assign head_y_s   = head_s[Y_BITS-1:0];
  assign head_x_s   = head_s[Y_BITS +: X_BITS];
  assign head_pol_s = head_s[EW-1];
  assign needs_y_s  = !(last_y_valid_r && (head_y_s == last_y_r));
  assign ev_ready   = !full_s;
  assign busy       = (state_r != IDLE) || !empty_s;

  // Two-flop synchronizer for the receiver's acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_meta_r <= 1'b0;
      ack_s      <= 1'b0;
    end else begin
      ack_meta_r <= ack;
      ack_s      <= ack_meta_r;
    end
  end

  // Event storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= {ev_pol, ev_x, ev_y};
    end
  end

  // FIFO pointers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= AW1'(0);
      rd_ptr_r <= AW1'(0);
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW1'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW1'(1);
    end
  end

  // Handshake FSM, event pacing and row tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r        <= IDLE;
      req            <= 1'b0;
      aer            <= 10'd0;
      xsel           <= 1'b0;
      event_count    <= 16'd0;
      setup_cnt_r    <= SW'(0);
      gap_cnt_r      <= GW'(0);
      idle_cnt_r     <= TW'(0);
      last_y_r       <= Y_BITS'(0);
      last_y_valid_r <= 1'b0;
      cur_y_r        <= Y_BITS'(0);
      cur_x_r        <= X_BITS'(0);
      cur_pol_r      <= 1'b0;
      first_rise_r   <= 1'b0;
    end else begin
      if (gap_cnt_r != GW'(0)) gap_cnt_r <= gap_cnt_r - GW'(1);

      if (pop_s) begin
        idle_cnt_r <= TW'(0);
      end else if ((state_r == IDLE) && empty_s && (idle_cnt_r != TIMEOUT)) begin
        idle_cnt_r <= idle_cnt_r + TW'(1);
      end
      // A Y completion later in this block takes priority over the timeout clear
      if (idle_cnt_r == TIMEOUT) last_y_valid_r <= 1'b0;

      case (state_r)
        IDLE: begin
          if (pop_s) begin
            cur_y_r      <= head_y_s;
            cur_x_r      <= head_x_s;
            cur_pol_r    <= head_pol_s;
            first_rise_r <= 1'b1;
            setup_cnt_r  <= SETUP_LOAD;
            state_r      <= SETUP;
            if (needs_y_s) begin
              aer  <= y_word(head_y_s);
              xsel <= 1'b0;
            end else begin
              aer  <= x_word(head_x_s, head_pol_s);
              xsel <= 1'b1;
            end
          end
        end
        SETUP: begin
          setup_cnt_r <= setup_cnt_r - SW'(1);
          if (setup_cnt_r <= SW'(1)) begin
            req     <= 1'b1;
            state_r <= REQ_HI;
            if (first_rise_r) begin
              gap_cnt_r    <= GAP_LOAD;
              first_rise_r <= 1'b0;
            end
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            req     <= 1'b0;
            state_r <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            if (!xsel) begin
              last_y_r       <= cur_y_r;
              last_y_valid_r <= 1'b1;
              aer            <= x_word(cur_x_r, cur_pol_r);
              xsel           <= 1'b1;
              setup_cnt_r    <= SETUP_LOAD;
              state_r        <= SETUP;
            end else begin
              event_count <= event_count + 16'd1;
              state_r     <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt_r == GW'(0)) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dvs_aer_tx.sv
// Self-checking bench for dvs_aer_tx: an ack responder, a word monitor and a row-aware
// reference model that predicts the word stream from the pushed events.
module tb_dvs_aer_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ev_valid = 1'b0;
  logic        ev_ready;
  logic [8:0]  ev_x = 9'd0;
  logic [8:0]  ev_y = 9'd0;
  logic        ev_pol = 1'b0;
  logic [9:0]  aer;
  logic        xsel;
  logic        req;
  logic        ack;
  logic        busy;
  logic [15:0] event_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int viol = 0;
  int ack_delay = 2;
  bit stall = 1'b0;
  int ack_rise_cyc = 0;
  int req_fall_cyc = 0;

  logic [10:0] exp_q[$];
  logic [10:0] got_q[$];
  int          start_q[$];
  logic        m_valid = 1'b0;
  logic [8:0]  m_last = 9'd0;
  int          exp_evcnt = 0;

  dvs_aer_tx dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_x(ev_x), .ev_y(ev_y), .ev_pol(ev_pol), .aer(aer), .xsel(xsel),
    .req(req), .ack(ack), .busy(busy), .event_count(event_count)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Receiver stand-in: follows req after ack_delay cycles, can be stalled low
  initial begin
    int cnt;
    cnt = 0;
    ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ack = 1'b0; cnt = 0;
      end else if ((ack != req) && !(stall && !ack)) begin
        cnt++;
        if (cnt >= ack_delay) begin
          ack = req; cnt = 0;
          if (ack) ack_rise_cyc = cyc;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Word capture on req rise, event-start times, and bus stability during handshakes
  initial begin
    logic        pr, prst, last_x;
    logic [10:0] pw;
    pr = 1'b0; prst = 1'b1; last_x = 1'b1; pw = 11'd0;
    forever begin
      @(negedge clk);
      if (!rst && !prst && (req || ack) && ({xsel, aer} !== pw)) viol++;
      if (!rst && req && !pr) begin
        got_q.push_back({xsel, aer});
        if (!xsel || last_x) start_q.push_back(cyc);
        last_x = xsel;
      end
      if (!rst && !req && pr) req_fall_cyc = cyc;
      if (rst) last_x = 1'b1;
      pr = rst ? 1'b0 : req;
      pw = {xsel, aer};
      prst = rst;
    end
  end

  task automatic push(input logic [8:0] x, input logic [8:0] y, input logic p, output int acc_cyc);
    int n;
    n = 0;
    acc_cyc = -1;
    @(negedge clk);
    while (!ev_ready && n < 3000) begin @(negedge clk); n++; end
    if (!ev_ready) begin
      checks++; errors++;
      $display("FAIL push_ready_timeout ev_ready=%0b required 1", ev_ready);
    end else begin
      ev_x = x; ev_y = y; ev_pol = p; ev_valid = 1'b1;
      @(posedge clk); #1;
      ev_valid = 1'b0;
      acc_cyc = cyc;
      if (!m_valid || y != m_last) begin
        exp_q.push_back({1'b0, 1'b0, y});
        m_last = y; m_valid = 1'b1;
      end
      exp_q.push_back({1'b1, x, p});
      exp_evcnt++;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || req || ack) && n < 6000) begin @(negedge clk); n++; end
    checks++;
    if (busy || req || ack) begin
      errors++;
      $display("FAIL %s_idle_timeout busy=%0b req=%0b ack=%0b required 0 0 0", name, busy, req, ack);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    got_q.delete(); exp_q.delete(); start_q.delete();
    m_valid = 1'b0; exp_evcnt = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req !== 1'b0)          begin errors++; $display("FAIL rst_req got %0b required 0", req); end
    checks++; if (aer !== 10'd0)         begin errors++; $display("FAIL rst_aer got %h required 000", aer); end
    checks++; if (xsel !== 1'b0)         begin errors++; $display("FAIL rst_xsel got %0b required 0", xsel); end
    checks++; if (ev_ready !== 1'b1)     begin errors++; $display("FAIL rst_ev_ready got %0b required 1", ev_ready); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got %0b required 0", busy); end
    checks++; if (event_count !== 16'd0) begin errors++; $display("FAIL rst_event_count got %0d required 0", event_count); end
    do_reset();
  endtask

  task automatic test_single();
    int pc;
    logic [10:0] w0, w1;
    ack_delay = 2;
    push(9'd5, 9'd7, 1'b1, pc);
    wait_idle("single");
    w0 = (got_q.size() > 0) ? got_q[0] : 11'bx;
    w1 = (got_q.size() > 1) ? got_q[1] : 11'bx;
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL single_words got %0d required 2", got_q.size()); end
    checks++; if (w0 !== 11'h007) begin errors++; $display("FAIL single_y_word got %h required 007", w0); end
    checks++; if (w1 !== 11'h40B) begin errors++; $display("FAIL single_x_word got %h required 40b", w1); end
    checks++; if (event_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d required 1", event_count); end
    checks++;
    if (start_q.size() < 1 || start_q[0] - pc != 2) begin
      errors++; $display("FAIL single_latency got %0d required 2", (start_q.size() > 0) ? start_q[0] - pc : -1);
    end
    checks++;
    if (req_fall_cyc - ack_rise_cyc != 3) begin
      errors++; $display("FAIL single_ack_to_req_fall got %0d required 3", req_fall_cyc - ack_rise_cyc);
    end
    got_q.delete(); exp_q.delete(); start_q.delete();
  endtask

  task automatic test_back_to_back();
    int pc;
    logic [10:0] w0, w1, w2;
    do_reset();
    ack_delay = 1;
    push(9'd3, 9'd7, 1'b0, pc);
    push(9'd9, 9'd7, 1'b1, pc);
    wait_idle("b2b");
    w0 = (got_q.size() > 0) ? got_q[0] : 11'bx;
    w1 = (got_q.size() > 1) ? got_q[1] : 11'bx;
    w2 = (got_q.size() > 2) ? got_q[2] : 11'bx;
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL b2b_words got %0d required 3", got_q.size()); end
    checks++; if (w0 !== 11'h007) begin errors++; $display("FAIL b2b_y_word got %h required 007", w0); end
    checks++; if (w1 !== 11'h406) begin errors++; $display("FAIL b2b_x0 got %h required 406", w1); end
    checks++; if (w2 !== 11'h413) begin errors++; $display("FAIL b2b_x1 got %h required 413", w2); end
    checks++;
    if (start_q.size() != 2 || start_q[1] - start_q[0] < 9) begin
      errors++; $display("FAIL b2b_event_spacing got %0d required >=9", (start_q.size() == 2) ? start_q[1] - start_q[0] : -1);
    end
    got_q.delete(); exp_q.delete(); start_q.delete();
    // Same row, no timeout yet: X word only
    push(9'd2, 9'd7, 1'b0, pc);
    wait_idle("row_hit");
    w0 = (got_q.size() > 0) ? got_q[0] : 11'bx;
    checks++; if (got_q.size() != 1 || w0 !== 11'h404) begin errors++; $display("FAIL row_hit got %0d words first %h required 1 words 404", got_q.size(), w0); end
    got_q.delete(); exp_q.delete(); start_q.delete();
  endtask

  task automatic test_row_timeout();
    int pc;
    logic [10:0] w0, w1;
    repeat (150) @(negedge clk);
    m_valid = 1'b0;
    push(9'd1, 9'd7, 1'b1, pc);
    wait_idle("timeout");
    w0 = (got_q.size() > 0) ? got_q[0] : 11'bx;
    w1 = (got_q.size() > 1) ? got_q[1] : 11'bx;
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL timeout_words got %0d required 2", got_q.size()); end
    checks++; if (w0 !== 11'h007) begin errors++; $display("FAIL timeout_y_resent got %h required 007", w0); end
    checks++; if (w1 !== 11'h403) begin errors++; $display("FAIL timeout_x_word got %h required 403", w1); end
    got_q.delete(); exp_q.delete(); start_q.delete();
  endtask

  task automatic test_stall();
    int pc, ready_hi;
    logic [15:0] cnt0;
    logic [10:0] w;
    cnt0 = event_count;
    exp_evcnt = event_count;
    ack_delay = 1;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_before_full got %0b required 1", ev_ready); end
      end
      push(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), pc);
    end
    ready_hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (ev_ready) ready_hi++;
    end
    checks++; if (ready_hi != 0) begin errors++; $display("FAIL stall_ready_low got %0d ready cycles required 0", ready_hi); end
    checks++; if (event_count !== cnt0) begin errors++; $display("FAIL stall_no_progress got %0d required %0d", event_count, cnt0); end
    stall = 1'b0;
    push(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), pc);
    wait_idle("stall");
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_words got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      w = (i < got_q.size()) ? got_q[i] : 11'bx;
      checks++; if (w !== exp_q[i]) begin errors++; $display("FAIL stall_word[%0d] got %h required %h", i, w, exp_q[i]); end
    end
    checks++; if (event_count !== 16'(exp_evcnt)) begin errors++; $display("FAIL stall_count got %0d required %0d", event_count, exp_evcnt); end
    got_q.delete(); exp_q.delete(); start_q.delete();
  endtask

  task automatic test_reset_mid();
    int pc, n;
    logic [10:0] w0, w1;
    ack_delay = 1;
    push(9'd6, 9'd7, 1'b1, pc);
    wait_idle("pre_reset");
    stall = 1'b1;
    push(9'd8, 9'd7, 1'b0, pc);
    n = 0;
    while (!req && n < 100) begin @(negedge clk); n++; end
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL rstmid_req_rise got %0b required 1", req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rstmid_req_drop got %0b required 0", req); end
    checks++; if (busy !== 1'b0 || ev_ready !== 1'b1) begin errors++; $display("FAIL rstmid_flush busy=%0b ev_ready=%0b required 0 1", busy, ev_ready); end
    stall = 1'b0;
    do_reset();
    push(9'd4, 9'd7, 1'b0, pc);
    wait_idle("post_reset");
    w0 = (got_q.size() > 0) ? got_q[0] : 11'bx;
    w1 = (got_q.size() > 1) ? got_q[1] : 11'bx;
    checks++; if (w0 !== 11'h007) begin errors++; $display("FAIL rstmid_y_resent got %h required 007", w0); end
    checks++; if (w1 !== 11'h408) begin errors++; $display("FAIL rstmid_x_word got %h required 408", w1); end
    checks++; if (event_count !== 16'd1) begin errors++; $display("FAIL rstmid_count got %0d required 1", event_count); end
    got_q.delete(); exp_q.delete(); start_q.delete();
  endtask

  task automatic test_random();
    int pc;
    logic [10:0] w;
    do_reset();
    for (int i = 0; i < 500; i++) begin
      ack_delay = $urandom_range(1, 3);
      push(9'($urandom_range(0, 511)), 9'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), pc);
    end
    wait_idle("random");
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL random_words got %0d required %0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      w = (i < got_q.size()) ? got_q[i] : 11'bx;
      checks++; if (w !== exp_q[i]) begin errors++; $display("FAIL random_word[%0d] got %h required %h", i, w, exp_q[i]); end
    end
    checks++; if (event_count !== 16'd500) begin errors++; $display("FAIL random_count got %0d required 500", event_count); end
    checks++; if (viol != 0) begin errors++; $display("FAIL bus_stability got %0d changes required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_row_timeout();
    test_stall();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
